// File: rtl/cnn_layer_accel_prefetch_ctrl.sv
// Row/column sequencer for one cnn_layer_accel_prefetch_buffer: requests row
// fetches from the DMA, streams read enables and flags row/frame boundaries.
module cnn_layer_accel_prefetch_ctrl #(
  parameter int C_CLG2_ROW_BUF_BRAM_DEPTH = 10,
  parameter int C_RD_LATENCY              = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 job_start,
  input  logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] num_rows,
  input  logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] num_cols,
  input  logic                                 padding,
  input  logic                                 upsample,
  input  logic                                 abort,
  input  logic                                 cncl_fetch_req,
  output logic                                 row_fetch_req,
  input  logic                                 row_fetch_done,
  input  logic                                 dout_ready,
  output logic                                 rd_en,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] input_row,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] input_col,
  output logic                                 next_row,
  output logic                                 rst_addr,
  output logic                                 pix_valid,
  output logic                                 job_complete,
  output logic                                 busy
);

  localparam int W = C_CLG2_ROW_BUF_BRAM_DEPTH;
  localparam logic [W-1:0] ONE = W'(1);

  // state   | meaning
  // IDLE    | waiting for job_start
  // DECIDE  | sample cncl_fetch_req for the current row
  // FETCH   | row_fetch_req held until row_fetch_done
  // READ    | rd_en follows dout_ready, col advances per read
  // ROW_END | next_row + rst_addr pulse, advance row or finish
  // DONE    | job_complete pulse
  typedef enum logic [2:0] {
    S_IDLE, S_DECIDE, S_FETCH, S_READ, S_ROW_END, S_DONE
  } state_t;

  state_t                  state;
  logic [W-1:0]            row;
  logic [W-1:0]            col;
  logic [W-1:0]            last_row;
  logic [W-1:0]            last_col;
  logic                    abort_q;
  logic [C_RD_LATENCY-1:0] rd_pipe;

  logic [W-1:0] rows_m1;
  logic [W-1:0] cols_m1;
  logic [W-1:0] last_row_c;
  logic [W-1:0] last_col_c;

  // Last index = eff-1; for upsample 2n-1 is (n-1) shifted left with a 1 appended.
  always_comb begin
    rows_m1    = num_rows - ONE;
    cols_m1    = num_cols - ONE;
    last_row_c = rows_m1;
    last_col_c = cols_m1;
    if (padding && !upsample) begin
      last_row_c = num_rows + ONE;
      last_col_c = num_cols + ONE;
    end else if (upsample && !padding) begin
      last_row_c = {rows_m1[W-2:0], 1'b1};
      last_col_c = {cols_m1[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      last_row <= '0;
      last_col <= '0;
      abort_q  <= 1'b0;
      rd_pipe  <= '0;
    end else begin
      abort_q    <= 1'b0;
      rd_pipe[0] <= rd_en;
      for (int i = 1; i < C_RD_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end

      if (abort && state != S_IDLE) begin
        state   <= S_IDLE;
        row     <= '0;
        col     <= '0;
        abort_q <= 1'b1;
        rd_pipe <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (job_start) begin
              last_row <= last_row_c;
              last_col <= last_col_c;
              row      <= '0;
              col      <= '0;
              state    <= S_DECIDE;
            end
          end
          S_DECIDE: state <= cncl_fetch_req ? S_READ : S_FETCH;
          S_FETCH: begin
            if (row_fetch_done) state <= S_READ;
          end
          S_READ: begin
            if (dout_ready) begin
              if (col == last_col) state <= S_ROW_END;
              else                 col   <= col + ONE;
            end
          end
          S_ROW_END: begin
            if (row == last_row) begin
              state <= S_DONE;
            end else begin
              row   <= row + ONE;
              col   <= '0;
              state <= S_DECIDE;
            end
          end
          S_DONE: begin
            row   <= '0;
            col   <= '0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_en         = (state == S_READ) && dout_ready;
  assign row_fetch_req = (state == S_FETCH);
  assign next_row      = (state == S_ROW_END);
  assign rst_addr      = next_row | abort_q;
  assign job_complete  = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign pix_valid     = rd_pipe[C_RD_LATENCY-1];
  assign input_row     = row;
  assign input_col     = col;

endmodule

// File: tb/tb_cnn_layer_accel_prefetch_ctrl.sv
// Randomised bench for cnn_layer_accel_prefetch_ctrl: a frame-walk model of
// expected reads, fetches and pulses is compared against the DUT every cycle.
module tb_cnn_layer_accel_prefetch_ctrl;
  localparam int W = 10;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         job_start;
  logic [W-1:0] num_rows;
  logic [W-1:0] num_cols;
  logic         padding;
  logic         upsample;
  logic         abort;
  logic         cncl_fetch_req;
  logic         row_fetch_req;
  logic         row_fetch_done;
  logic         dout_ready;
  logic         rd_en;
  logic [W-1:0] input_row;
  logic [W-1:0] input_col;
  logic         next_row;
  logic         rst_addr;
  logic         pix_valid;
  logic         job_complete;
  logic         busy;

  int           total = 0;
  int           bad = 0;
  logic [63:0]  cncl_mask = '0;
  int           ready_mode = 0;
  int           dma_lat = 1;
  int           req_cnt = 0;
  logic [L-1:0] rd_hist = '0;

  typedef struct { int r; int c; } rc_t;

  always #5 clk = ~clk;

  // Stand-in for the buffer's cancel decision: a per-row mask.
  assign cncl_fetch_req = cncl_mask[input_row[5:0]];

  cnn_layer_accel_prefetch_ctrl #(
    .C_CLG2_ROW_BUF_BRAM_DEPTH(W),
    .C_RD_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .num_rows(num_rows),
    .num_cols(num_cols), .padding(padding), .upsample(upsample), .abort(abort),
    .cncl_fetch_req(cncl_fetch_req), .row_fetch_req(row_fetch_req),
    .row_fetch_done(row_fetch_done), .dout_ready(dout_ready), .rd_en(rd_en),
    .input_row(input_row), .input_col(input_col), .next_row(next_row),
    .rst_addr(rst_addr), .pix_valid(pix_valid), .job_complete(job_complete),
    .busy(busy)
  );

  // One cycle: DMA responder and ready driven at negedge, outputs sampled 1ns later.
  task automatic step();
    @(negedge clk);
    if (row_fetch_req) req_cnt++;
    else               req_cnt = 0;
    row_fetch_done = row_fetch_req && (req_cnt == dma_lat + 1);
    dout_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    total++;
    if (pix_valid !== rd_hist[L-1]) begin
      bad++;
      $display("FAIL pix_valid: got %b required %b", pix_valid, rd_hist[L-1]);
    end
    total++;
    if (rd_en === 1'b1 && dout_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_en_gate: rd_en=%b while dout_ready=%b", rd_en, dout_ready);
    end
    rd_hist = {rd_hist[L-2:0], rd_en};
  endtask

  task automatic run_job(input int nr, input int nc, input bit pad, input bit up,
                         input logic [63:0] mask, input int rmode, input int lat,
                         input bit hold_done);
    int  er, ec, exp_cycles, exp_fetch, cyc, rd_cnt, fetch_cnt, nr_cnt;
    bit  done, prev_req;
    rc_t q[$];
    rc_t e;
    er = (pad && !up) ? nr + 2 : (up && !pad) ? 2 * nr : nr;
    ec = (pad && !up) ? nc + 2 : (up && !pad) ? 2 * nc : nc;
    exp_cycles = 1;
    exp_fetch  = 0;
    for (int r = 0; r < er; r++) begin
      if (mask[r]) exp_cycles += ec + 2;
      else begin
        exp_cycles += ec + 3 + lat;
        exp_fetch++;
      end
      for (int c = 0; c < ec; c++) q.push_back('{r, c});
    end

    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_idle: busy=%b required 0", busy);
    end
    num_rows = W'(nr); num_cols = W'(nc); padding = pad; upsample = up;
    cncl_mask = mask; ready_mode = rmode; dma_lat = lat; job_start = 1'b1;

    cyc = 0; rd_cnt = 0; fetch_cnt = 0; nr_cnt = 0; done = 0; prev_req = 0;
    while (!done && cyc < 4000) begin
      step();
      job_start = 1'b0;
      cyc++;
      if (rd_en === 1'b1) begin
        rd_cnt++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rd_extra: row=%0d col=%0d required no read", input_row, input_col);
        end else begin
          e = q.pop_front();
          if (input_row !== W'(e.r) || input_col !== W'(e.c)) begin
            bad++;
            $display("FAIL rd_order: row=%0d col=%0d required row=%0d col=%0d",
                     input_row, input_col, e.r, e.c);
          end
        end
      end
      if (row_fetch_req === 1'b1 && !prev_req) begin
        fetch_cnt++;
        total++;
        if (mask[input_row[5:0]]) begin
          bad++;
          $display("FAIL fetch_cancelled: fetch on row %0d required none", input_row);
        end
      end
      prev_req = (row_fetch_req === 1'b1);
      total++;
      if (rst_addr !== next_row) begin
        bad++;
        $display("FAIL rst_addr_align: rst_addr=%b required %b", rst_addr, next_row);
      end
      if (next_row === 1'b1) nr_cnt++;
      if (job_complete === 1'b1) begin
        done = 1;
        job_start = hold_done;
      end
    end

    total++;
    if (!done) begin
      bad++;
      $display("FAIL job_timeout: no job_complete after %0d cycles, required one", cyc);
    end
    if (rmode == 0) begin
      total++;
      if (cyc !== exp_cycles) begin
        bad++;
        $display("FAIL job_cycles: got %0d required %0d", cyc, exp_cycles);
      end
    end
    total++;
    if (rd_cnt !== er * ec || q.size() != 0) begin
      bad++;
      $display("FAIL rd_count: got %0d required %0d", rd_cnt, er * ec);
    end
    total++;
    if (fetch_cnt !== exp_fetch) begin
      bad++;
      $display("FAIL fetch_count: got %0d required %0d", fetch_cnt, exp_fetch);
    end
    total++;
    if (nr_cnt !== er) begin
      bad++;
      $display("FAIL next_row_count: got %0d required %0d", nr_cnt, er);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; job_start = 0; num_rows = '0; num_cols = '0; padding = 0;
    upsample = 0; abort = 0; row_fetch_done = 0; dout_ready = 0;
    #3;
    total++;
    if ({rd_en, row_fetch_req, next_row, rst_addr, pix_valid, job_complete, busy,
         input_row, input_col} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b row=%0d col=%0d required all 0",
               busy, input_row, input_col);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_job(2, 4, 0, 0, 64'h0, 0, 3, 0);
    drain(4);
  endtask

  task automatic test_upsample();
    run_job(2, 3, 0, 1, 64'hA, 0, 2, 0);
    drain(4);
  endtask

  task automatic test_padding();
    run_job(3, 3, 1, 0, 64'h11, 0, 1, 0);
    drain(4);
  endtask

  task automatic test_ready_toggle();
    run_job(3, 4, 0, 0, 64'h2, 1, 2, 0);
    drain(4);
    ready_mode = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)), 0);
      drain(3);
    end
    ready_mode = 0;
  endtask

  task automatic test_abort();
    int  n;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    total++;
    if (rst_addr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: rst_addr=%b busy=%b required 0 0", rst_addr, busy);
    end

    num_rows = W'(2); num_cols = W'(5); padding = 0; upsample = 0;
    cncl_mask = '0; dma_lat = 50; job_start = 1'b1;
    step();
    job_start = 1'b0;
    n = 0;
    while (row_fetch_req !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (row_fetch_req !== 1'b1) begin
      bad++;
      $display("FAIL abort_fetch_wait: row_fetch_req=%b required 1", row_fetch_req);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || rst_addr !== 1'b1 || row_fetch_req !== 1'b0 ||
        input_row !== '0 || input_col !== '0 || job_complete !== 1'b0) begin
      bad++;
      $display("FAIL abort_fetch: busy=%b rst_addr=%b req=%b row=%0d col=%0d jc=%b required 0 1 0 0 0 0",
               busy, rst_addr, row_fetch_req, input_row, input_col, job_complete);
    end
    step();
    total++;
    if (rst_addr !== 1'b0 || job_complete !== 1'b0) begin
      bad++;
      $display("FAIL abort_fetch_after: rst_addr=%b jc=%b required 0 0", rst_addr, job_complete);
    end

    num_rows = W'(2); num_cols = W'(6); dma_lat = 2; job_start = 1'b1;
    step();
    job_start = 1'b0;
    n = 0;
    while (!(rd_en === 1'b1 && input_col === W'(2)) && n < 30) begin step(); n++; end
    total++;
    if (!(rd_en === 1'b1 && input_col === W'(2))) begin
      bad++;
      $display("FAIL abort_read_wait: rd_en=%b col=%0d required 1 2", rd_en, input_col);
    end
    abort = 1'b1;
    rd_hist = '0;
    step();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || rst_addr !== 1'b1 || rd_en !== 1'b0 || pix_valid !== 1'b0 ||
        input_col !== '0 || job_complete !== 1'b0) begin
      bad++;
      $display("FAIL abort_read: busy=%b rst_addr=%b rd_en=%b pv=%b col=%0d jc=%b required 0 1 0 0 0 0",
               busy, rst_addr, rd_en, pix_valid, input_col, job_complete);
    end
    drain(3);
    run_job(2, 3, 0, 0, 64'h0, 0, 1, 0);
    drain(3);
  endtask

  task automatic test_back_to_back();
    int n;
    run_job(2, 2, 0, 0, 64'h1, 0, 1, 1);
    run_job(1, 3, 1, 0, 64'h1, 0, 2, 0);

    num_rows = W'(3); num_cols = W'(5); padding = 0; upsample = 0;
    cncl_mask = '0; dma_lat = 1; job_start = 1'b1;
    step();
    job_start = 1'b0;
    n = 0;
    while (!(rd_en === 1'b1 && input_row === W'(1) && input_col === W'(2)) && n < 60) begin
      step(); n++;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rd_en, row_fetch_req, next_row, rst_addr, pix_valid, job_complete, busy,
         input_row, input_col} !== '0) begin
      bad++;
      $display("FAIL async_reset: rd_en=%b busy=%b row=%0d col=%0d pv=%b required all 0",
               rd_en, busy, input_row, input_col, pix_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_hist = '0;
    req_cnt = 0;
    run_job(2, 2, 0, 1, 64'h0, 0, 0, 0);
    drain(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_upsample();
    test_padding();
    test_ready_toggle();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
